weight_stream_sink: RTL and testbench
=====================================

WEIGHT_STREAM_SINK -- requirements
Module: weight_stream_sink

Interface
REQ-001 SHALL have parameter DATA_PRECISION_0, default 16, total bit width of one element.
REQ-002 SHALL have parameter DATA_PRECISION_1, default 3, fractional bits; carried for metadata only, no arithmetic.
REQ-003 SHALL have parameter TENSOR_SIZE_DIM_0, default 32, tensor columns.
REQ-004 SHALL have parameter TENSOR_SIZE_DIM_1, default 1, tensor rows.
REQ-005 SHALL have parameter PARALLELISM_DIM_0, default 4, elements per beat along dim 0; must divide TENSOR_SIZE_DIM_0.
REQ-006 SHALL have parameter PARALLELISM_DIM_1, default 1, elements per beat along dim 1; must divide TENSOR_SIZE_DIM_1.
REQ-007 SHALL have derived parameter DEPTH = (TENSOR_SIZE_DIM_0/PARALLELISM_DIM_0)*(TENSOR_SIZE_DIM_1/PARALLELISM_DIM_1), beats per tensor.
REQ-008 SHALL have port clk  input  1  clock; all logic on the rising edge.
REQ-009 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-010 SHALL have port data_in  input  unpacked array [P0*P1] of DATA_PRECISION_0  one beat of elements; element j is stored at bits [DATA_PRECISION_0*j +: DATA_PRECISION_0].
REQ-011 SHALL have port data_in_valid  input  1  beat valid.
REQ-012 SHALL have port data_in_ready  output  1  sink accepts a beat.
REQ-013 SHALL have port load_start  input  1  single-cycle pulse; arms or restarts capture.
REQ-014 SHALL have port load_done  output  1  level; a complete tensor is stored.
REQ-015 SHALL have port beat_count  output  $clog2(DEPTH)+1  number of beats captured in the current load.
REQ-016 SHALL have port rd_addr  input  $clog2(DEPTH)+1  readback beat address.
REQ-017 SHALL have port rd_en  input  1  readback request.
REQ-018 SHALL have port rd_data  output  DATA_PRECISION_0*P0*P1  readback beat.
REQ-019 SHALL have port rd_valid  output  1  rd_data is valid this cycle.

Function
REQ-020 SHALL implement FSM states IDLE, LOAD and FULL.
REQ-021 SHALL transition IDLE->LOAD on load_start, clearing the write pointer and beat_count to 0.
REQ-022 SHALL drive data_in_ready=1 only in LOAD; a handshake is data_in_valid & data_in_ready.
REQ-023 SHALL, on each handshake, write data_in to mem[wr_ptr], then increment wr_ptr and beat_count.
REQ-024 SHALL transition LOAD->FULL on the handshake of beat DEPTH-1; load_done SHALL rise the following cycle and data_in_ready SHALL be 0 from that cycle on.
REQ-025 SHALL treat load_start in LOAD or FULL as a restart: go to (or stay in) LOAD, set wr_ptr=0, beat_count=0, load_done=0; a beat presented in the same cycle SHALL be discarded.
REQ-026 SHALL ignore data_in_valid in IDLE and FULL, with no pointer change.
REQ-027 SHALL implement readback with latency exactly 2 cycles: rd_en at cycle t gives rd_data/rd_valid at t+2; reads are fully pipelined, one per cycle.
REQ-028 SHALL return all-zero rd_data, with rd_valid still asserted, for rd_addr >= DEPTH.
REQ-029 SHALL, on a same-cycle write and read to the same address, return the old contents (read-first).
REQ-030 SHALL allow reads in any state; rd_valid SHALL be independent of the FSM.
REQ-031 SHALL keep beat_count <= DEPTH at all times and hold it at DEPTH in FULL.

Reset
REQ-032 SHALL on rst: state=IDLE, wr_ptr=0, beat_count=0, load_done=0, data_in_ready=0, rd_valid pipeline=0, rd_data=0.
REQ-033 SHALL NOT clear memory contents on reset.
REQ-034 SHALL give rst priority over load_start and handshakes in the same cycle, including mid-LOAD.

Structure
REQ-035 SHALL place the state enum (IDLE/LOAD/FULL) and a depth-calculation function in package weight_stream_sink_pkg.
REQ-036 SHALL instantiate one sub-module, weight_stream_sink_ram: simple dual-port, one write port, one read port with 2-cycle registered read.

Verification
REQ-037 SHALL cover full load: load_start, 8 beats with element value = 16'(beat*4+j), valid held high -> load_done after 8th handshake+1, beat_count=8; reading addr 3 returns elements 12..15 two cycles later.
REQ-038 SHALL cover backpressure/gaps: valid toggled 1,0,1,0 -> only valid cycles written, beat_count increments only on handshakes.
REQ-039 SHALL cover restart mid-load: load_start after 5 beats, then 8 new beats -> new data at addr 0..7, no stale beats, load_done once.
REQ-040 SHALL cover reset mid-LOAD after 3 beats -> outputs zero next cycle; readback of addr 0..2 still returns the stored beats.
REQ-041 SHALL cover read edge cases: rd_addr=8 -> rd_data=0, rd_valid=1; same-cycle write/read to addr 2 -> old value returned.
REQ-042 SHALL cover extra beats in FULL: 4 further valid beats -> data_in_ready=0, memory unchanged, beat_count stays 8.

Source files
------------

// File: rtl/weight_stream_sink_pkg.sv
// Shared types and helpers for the weight stream sink.
// Holds the capture FSM state enum and the tensor depth calculation.
package weight_stream_sink_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        FULL = 2'd2
    } ws_state_t;

    // Beats needed to move one whole tensor.
    function automatic int calc_depth(
        input int t0,
        input int t1,
        input int p0,
        input int p1
    );
        return (t0 / p0) * (t1 / p1);
    endfunction

endpackage

// File: rtl/weight_stream_sink_ram.sv
// Simple dual-port beat store: one write port, one read port with a
// two-stage registered read. Ports: clk/rst, we/waddr/wdata, re/raddr, rdata/rvalid.
module weight_stream_sink_ram #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 8,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata,
    output logic             rvalid
);

    localparam int IW = AW - 1;

    logic [WIDTH-1:0] mem [2**IW];

    logic             v1_q, v1_d;
    logic             v2_q, v2_d;
    logic [WIDTH-1:0] d1_q, d1_d;
    logic [WIDTH-1:0] d2_q, d2_d;

    // Contents survive reset on purpose.
    always_ff @(posedge clk) begin
        if (we && !waddr[AW-1]) begin
            mem[waddr[IW-1:0]] <= wdata;
        end
    end

    // Stage 1 samples the array on the same edge as a write, so a
    // colliding read sees the old word.
    always_comb begin
        v1_d = re;
        d1_d = '0;
        if (raddr < AW'(DEPTH)) begin
            d1_d = mem[raddr[IW-1:0]];
        end
        v2_d = v1_q;
        d2_d = d1_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            d1_q <= '0;
            d2_q <= '0;
        end else begin
            v1_q <= v1_d;
            v2_q <= v2_d;
            d1_q <= d1_d;
            d2_q <= d2_d;
        end
    end

    assign rdata  = d2_q;
    assign rvalid = v2_q;

endmodule

// File: rtl/weight_stream_sink.sv
// Captures one tensor of weight beats into a local store and offers readback.
// Ports: clk/rst, data_in stream (valid/ready), load_start/load_done,
// beat_count, and a 2-cycle readback port (rd_addr/rd_en -> rd_data/rd_valid).
module weight_stream_sink
    import weight_stream_sink_pkg::*;
#(
    parameter int DATA_PRECISION_0  = 16,
    parameter int DATA_PRECISION_1  = 3,
    parameter int TENSOR_SIZE_DIM_0 = 32,
    parameter int TENSOR_SIZE_DIM_1 = 1,
    parameter int PARALLELISM_DIM_0 = 4,
    parameter int PARALLELISM_DIM_1 = 1,
    parameter int DEPTH = calc_depth(TENSOR_SIZE_DIM_0, TENSOR_SIZE_DIM_1,
                                     PARALLELISM_DIM_0, PARALLELISM_DIM_1),
    localparam int NP = PARALLELISM_DIM_0 * PARALLELISM_DIM_1,
    localparam int AW = $clog2(DEPTH) + 1,
    localparam int BW = DATA_PRECISION_0 * NP
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DATA_PRECISION_0-1:0] data_in [NP],
    input  logic                        data_in_valid,
    output logic                        data_in_ready,
    input  logic                        load_start,
    output logic                        load_done,
    output logic [AW-1:0]               beat_count,
    input  logic [AW-1:0]               rd_addr,
    input  logic                        rd_en,
    output logic [BW-1:0]               rd_data,
    output logic                        rd_valid
);

    // Parallelism must tile the tensor and the fraction must fit the word.
    if ((TENSOR_SIZE_DIM_0 % PARALLELISM_DIM_0) != 0 ||
        (TENSOR_SIZE_DIM_1 % PARALLELISM_DIM_1) != 0 ||
        DATA_PRECISION_1 > DATA_PRECISION_0) begin : g_bad_cfg
        $error("weight_stream_sink: illegal parameter set");
    end

    ws_state_t     state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] beat_count_q, beat_count_d;
    logic          we;
    logic [BW-1:0] wdata;

    always_comb begin
        wdata = '0;
        for (int j = 0; j < NP; j++) begin
            wdata[DATA_PRECISION_0*j +: DATA_PRECISION_0] = data_in[j];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            beat_count_q <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            beat_count_q <= beat_count_d;
        end
    end

    // load_start wins over a same-cycle beat, which is dropped.
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        beat_count_d = beat_count_q;
        we           = 1'b0;
        if (load_start) begin
            state_d      = LOAD;
            wr_ptr_d     = '0;
            beat_count_d = '0;
        end else begin
            unique case (state_q)
                LOAD: begin
                    if (data_in_valid) begin
                        we           = !rst;
                        wr_ptr_d     = wr_ptr_q + 1'b1;
                        beat_count_d = beat_count_q + 1'b1;
                        if (wr_ptr_q == AW'(DEPTH - 1)) begin
                            state_d = FULL;
                        end
                    end
                end
                IDLE, FULL: begin
                    state_d = state_q;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_comb begin
        data_in_ready = (state_q == LOAD);
        load_done     = (state_q == FULL);
        beat_count    = beat_count_q;
    end

    weight_stream_sink_ram #(
        .WIDTH (BW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk    (clk),
        .rst    (rst),
        .we     (we),
        .waddr  (wr_ptr_q),
        .wdata  (wdata),
        .re     (rd_en),
        .raddr  (rd_addr),
        .rdata  (rd_data),
        .rvalid (rd_valid)
    );

endmodule

// File: tb/tb_weight_stream_sink.sv
// Directed bench for weight_stream_sink with the default 8-beat tensor.
// Covers load, gaps, restart, reset mid-load, readback edges and FULL overrun.
module tb_weight_stream_sink;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] data_in [4];
    logic        data_in_valid;
    logic        data_in_ready;
    logic        load_start;
    logic        load_done;
    logic [3:0]  beat_count;
    logic [3:0]  rd_addr;
    logic        rd_en;
    logic [63:0] rd_data;
    logic        rd_valid;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    weight_stream_sink dut (
        .clk           (clk),
        .rst           (rst),
        .data_in       (data_in),
        .data_in_valid (data_in_valid),
        .data_in_ready (data_in_ready),
        .load_start    (load_start),
        .load_done     (load_done),
        .beat_count    (beat_count),
        .rd_addr       (rd_addr),
        .rd_en         (rd_en),
        .rd_data       (rd_data),
        .rd_valid      (rd_valid)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] beat_word(input int base, input int b);
        logic [63:0] w;
        for (int j = 0; j < 4; j++) w[16*j +: 16] = 16'(base + b*4 + j);
        return w;
    endfunction

    task automatic set_beat(input int base, input int b);
        for (int j = 0; j < 4; j++) data_in[j] = 16'(base + b*4 + j);
    endtask

    task automatic pulse_start;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    // Beats [from, to) with valid held high.
    task automatic load_beats(input int base, input int from, input int to);
        data_in_valid = 1'b1;
        for (int b = from; b < to; b++) begin
            set_beat(base, b);
            tick();
            check($sformatf("cnt_b%0d", b), beat_count, 64'(b + 1));
            check($sformatf("done_b%0d", b), load_done, 64'(b == 7));
            check($sformatf("rdy_b%0d", b), data_in_ready, 64'(b != 7));
        end
        data_in_valid = 1'b0;
    endtask

    task automatic read_one(input int a, input logic [63:0] exp,
                            input string tag);
        rd_en   = 1'b1;
        rd_addr = 4'(a);
        tick();
        rd_en = 1'b0;
        check({tag, "_early"}, rd_valid, 64'd0);
        tick();
        check({tag, "_v"}, rd_valid, 64'd1);
        check({tag, "_d"}, rd_data, exp);
    endtask

    // Back-to-back reads of addr 0..7, one per cycle.
    task automatic read_all(input int base, input string tag);
        for (int i = 0; i <= 8; i++) begin
            rd_en   = (i < 8);
            rd_addr = 4'(i);
            tick();
            if (i >= 1) begin
                check($sformatf("%s_v%0d", tag, i - 1), rd_valid, 64'd1);
                check($sformatf("%s_d%0d", tag, i - 1), rd_data,
                      beat_word(base, i - 1));
            end
        end
        rd_en = 1'b0;
    endtask

    initial begin
        int b;
        rst           = 1'b1;
        data_in_valid = 1'b0;
        load_start    = 1'b0;
        rd_en         = 1'b0;
        rd_addr       = '0;
        set_beat(0, 0);
        tick();
        tick();
        check("rst_rdy", data_in_ready, 64'd0);
        check("rst_done", load_done, 64'd0);
        check("rst_cnt", beat_count, 64'd0);
        check("rst_rv", rd_valid, 64'd0);
        check("rst_rd", rd_data, 64'd0);
        rst = 1'b0;

        // IDLE ignores beats.
        data_in_valid = 1'b1;
        tick();
        check("idle_cnt", beat_count, 64'd0);
        check("idle_rdy", data_in_ready, 64'd0);
        data_in_valid = 1'b0;

        // Full load.
        pulse_start();
        check("ld_cnt0", beat_count, 64'd0);
        check("ld_rdy0", data_in_ready, 64'd1);
        load_beats(0, 0, 8);
        read_one(3, 64'h000F_000E_000D_000C, "rd3");
        read_all(0, "ld");

        // Overrun in FULL.
        data_in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            set_beat(16'h700, k);
            tick();
            check("full_rdy", data_in_ready, 64'd0);
            check("full_cnt", beat_count, 64'd8);
            check("full_done", load_done, 64'd1);
        end
        data_in_valid = 1'b0;
        read_all(0, "full");

        // Out-of-range read.
        read_one(8, 64'd0, "oor");

        // Valid toggling.
        pulse_start();
        b = 0;
        for (int c = 0; c < 16; c++) begin
            data_in_valid = (c % 2 == 0);
            set_beat(16'h200, b);
            tick();
            if (c % 2 == 0) b++;
            check($sformatf("gap_cnt%0d", c), beat_count, 64'(b));
        end
        data_in_valid = 1'b0;
        check("gap_done", load_done, 64'd1);
        read_all(16'h200, "gap");

        // Restart after 5 beats; the beat beside load_start is dropped.
        pulse_start();
        load_beats(16'h300, 0, 5);
        load_start    = 1'b1;
        data_in_valid = 1'b1;
        set_beat(16'h3F0, 0);
        tick();
        load_start    = 1'b0;
        data_in_valid = 1'b0;
        check("rs_cnt", beat_count, 64'd0);
        check("rs_rdy", data_in_ready, 64'd1);
        check("rs_done", load_done, 64'd0);
        load_beats(16'h400, 0, 8);
        read_all(16'h400, "rs");

        // Same-cycle write and read of addr 2.
        pulse_start();
        load_beats(16'h500, 0, 2);
        data_in_valid = 1'b1;
        set_beat(16'h500, 2);
        rd_en   = 1'b1;
        rd_addr = 4'd2;
        tick();
        rd_en = 1'b0;
        check("col_cnt", beat_count, 64'd3);
        set_beat(16'h500, 3);
        tick();
        check("col_v", rd_valid, 64'd1);
        check("col_old", rd_data, beat_word(16'h400, 2));
        load_beats(16'h500, 4, 8);
        read_one(2, beat_word(16'h500, 2), "col_new");

        // Reset during LOAD with a beat on the same edge.
        pulse_start();
        load_beats(16'h600, 0, 3);
        data_in_valid = 1'b1;
        set_beat(16'h600, 3);
        rst = 1'b1;
        tick();
        check("mr_cnt", beat_count, 64'd0);
        check("mr_rdy", data_in_ready, 64'd0);
        check("mr_done", load_done, 64'd0);
        check("mr_rv", rd_valid, 64'd0);
        check("mr_rd", rd_data, 64'd0);
        rst           = 1'b0;
        data_in_valid = 1'b0;
        read_one(0, beat_word(16'h600, 0), "mr0");
        read_one(1, beat_word(16'h600, 1), "mr1");
        read_one(2, beat_word(16'h600, 2), "mr2");
        read_one(3, beat_word(16'h500, 3), "mr3");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
